result_bcd_converter: RTL and testbench
=======================================

// Module: result_bcd_converter
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) sitting directly
//  upstream of display_top: turns the 32-bit arithmetic result into decimal digits for the
//  two 4-digit display pages. Also reports sign, digit count and overflow beyond 8 digits.
//  Start/busy/done handshake with the arithmetic module; bcd_out is held stable between conversions.
// PARAMETERS
//  IN_WIDTH     32  width of bin_in; sets SHIFT-phase length
//  NUM_DIGITS   10  BCD digits produced; 10 covers 2^32-1
//  DISP_DIGITS   8  digits the display can show; higher nonzero digits raise overflow
// PORTS
//  clk          in   1              system clock (100 MHz)
//  reset        in   1              reset, synchronous, active-high
//  start        in   1              request conversion of bin_in; sampled in IDLE/DONE only
//  signed_mode  in   1              1: bin_in is two's complement; 0: unsigned
//  bin_in       in   IN_WIDTH       value to convert; captured on the accepting edge
//  busy         out  1              high in LOAD and SHIFT
//  done         out  1              one-cycle pulse; outputs valid from this cycle
//  bcd_out      out  4*NUM_DIGITS   packed BCD magnitude, digit 0 (ones) in [3:0]
//  negative     out  1              result was negative (signed_mode only)
//  overflow     out  1              magnitude > 10^DISP_DIGITS-1 (99,999,999)
//  digit_count  out  4              significant digits, 1..NUM_DIGITS (zero -> 1)
// BEHAVIOUR
//  - Reset: FSM->IDLE; busy=0, done=0, bcd_out=0, negative=0, overflow=0, digit_count=1.
//  - FSM: IDLE -start-> LOAD -> SHIFT (IN_WIDTH cycles) -> DONE -> IDLE.
//    DONE lasts exactly one cycle; start sampled high in DONE goes straight to LOAD.
//  - LOAD: latch sign = signed_mode & bin_in[IN_WIDTH-1]; magnitude = sign ? -bin_in : bin_in
//    (IN_WIDTH-bit unsigned; -2^31 -> 2147483648 fits). Clear BCD scratch, bit counter=0.
//  - SHIFT per cycle: each BCD digit >=5 gets +3, then {bcd,mag} shifts left by 1; counter+1;
//    leave when counter==IN_WIDTH-1.
//  - DONE: register bcd_out, negative, overflow, digit_count from scratch; done=1.
//  - Latency: done is high exactly IN_WIDTH+2 clocks after the edge that accepts start (34).
//  - start while busy: ignored, no queueing; bin_in changes during busy: no effect.
//  - Outputs change only in the DONE cycle (or reset); held otherwise.
//  - overflow = OR of digit_nonzero[NUM_DIGITS-1:DISP_DIGITS]. digit_count = index of the
//    highest nonzero digit + 1, or 1 when all digits are zero.
//  - negative is forced to 0 when the magnitude is 0.
//  - Reset mid-conversion: aborts, no done pulse, all outputs take reset values.
//  - The BCD scratch never exceeds 9 per digit; no digit value > 9 ever appears on bcd_out.
// STRUCTURE
//  - Shared header display_defs.vh: FSM state encodings (IDLE/LOAD/SHIFT/DONE),
//    BCD_W=4, and DISP_DIGITS/NUM_DIGITS defaults shared with display_top paging.
//  - Sub-module dabble_digit: combinational 4-bit add-3-if->=5 cell, instantiated
//    NUM_DIGITS times in a generate loop. Everything else (FSM, counter, regs) lives in this module.
// TESTING
//  1. unsigned 0 -> done at +34, bcd_out=0, digit_count=1, negative=0, overflow=0.
//  2. unsigned 12345678 -> bcd_out=40'h0012345678, digit_count=8, overflow=0.
//  3. unsigned 100000000 -> bcd_out=40'h0100000000, digit_count=9, overflow=1.
//  4. signed 32'hFFFFFFFF -> bcd_out=1, negative=1; signed 32'h80000000 ->
//     40'h2147483648, negative=1, overflow=1; unsigned 32'hFFFFFFFF -> 40'h4294967295.
//  5. start held high through busy with bin_in toggling -> one conversion per accept;
//     back-to-back start in DONE -> next done exactly 34 clocks later, no idle gap.
//  6. reset asserted at SHIFT cycle 10 -> no done, outputs at reset values next cycle;
//     a following start converts correctly.

Source files
------------

// File: rtl/result_bcd_converter_pkg.sv
// -----------------------------------------------------------------------------
// result_bcd_converter_pkg
// Purpose : Shared definitions for the binary-to-BCD result converter and the
//           display paging logic downstream of it: FSM state encoding, BCD
//           digit width, default digit counts and the double-dabble cell rule.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package result_bcd_converter_pkg;

    localparam int BCD_W            = 4;   // bits per BCD digit
    localparam int IN_WIDTH_DEF     = 32;  // default binary input width
    localparam int NUM_DIGITS_DEF   = 10;  // 10 digits cover 2^32-1
    localparam int DISP_DIGITS_DEF  = 8;   // digits across the two display pages

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    // Double-dabble correction: a digit of 5..9 would become >=10 after the
    // next left shift, so pre-add 3 so the shift carries into the next digit.
    function automatic logic [BCD_W-1:0] add3_if_ge5(input logic [BCD_W-1:0] d);
        return (d >= BCD_W'(5)) ? (d + BCD_W'(3)) : d;
    endfunction

endpackage

// File: rtl/result_bcd_converter_dabble_digit.sv
// -----------------------------------------------------------------------------
// result_bcd_converter_dabble_digit
// Purpose : Combinational add-3-if-at-least-5 cell for one BCD digit of the
//           shift-and-add-3 converter.
// Ports   : digit_i  in   BCD_W   current scratch digit
//           digit_o  out  BCD_W   corrected digit, ready to be shifted left
// -----------------------------------------------------------------------------
module result_bcd_converter_dabble_digit
    import result_bcd_converter_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    assign digit_o = add3_if_ge5(digit_i);

endmodule

// File: rtl/result_bcd_converter.sv
// -----------------------------------------------------------------------------
// result_bcd_converter
// Purpose : Sequential binary-to-BCD converter (shift-and-add-3, one bit per
//           clock) feeding the display. Converts the arithmetic result into
//           NUM_DIGITS decimal digits and reports sign, significant digit
//           count and overflow beyond DISP_DIGITS digits.
//           Handshake: start accepted in IDLE/DONE, busy during LOAD/SHIFT,
//           one-cycle done pulse. Outputs are held between conversions.
// Ports   : clk          in   1                 system clock
//           reset        in   1                 synchronous, active-high reset
//           start        in   1                 request conversion of bin_in
//           signed_mode  in   1                 1: bin_in is two's complement
//           bin_in       in   IN_WIDTH          value, captured on accept edge
//           busy         out  1                 high in LOAD and SHIFT
//           done         out  1                 one-cycle pulse, results valid
//           bcd_out      out  BCD_W*NUM_DIGITS  packed BCD magnitude, ones in [3:0]
//           negative     out  1                 result negative (nonzero only)
//           overflow     out  1                 magnitude exceeds DISP_DIGITS digits
//           digit_count  out  4                 significant digits, 1..NUM_DIGITS
// -----------------------------------------------------------------------------
module result_bcd_converter
    import result_bcd_converter_pkg::*;
#(
    parameter int IN_WIDTH    = IN_WIDTH_DEF,
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
    parameter int DISP_DIGITS = DISP_DIGITS_DEF
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          signed_mode,
    input  logic [IN_WIDTH-1:0]           bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_W*NUM_DIGITS-1:0]   bcd_out,
    output logic                          negative,
    output logic                          overflow,
    output logic [3:0]                    digit_count
);

    localparam int CNT_W   = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int BCD_TOT = BCD_W * NUM_DIGITS;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    conv_state_t            state_q;
    logic [IN_WIDTH-1:0]    bin_q;        // operand captured on accept
    logic                   smode_q;
    logic                   sign_q;
    logic [IN_WIDTH-1:0]    mag_q;        // magnitude, shifted out MSB first
    logic [BCD_TOT-1:0]     scratch_q;    // BCD accumulator
    logic                   lost_q;       // a BCD bit fell off the top digit
    logic [CNT_W-1:0]       cnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic [BCD_TOT-1:0]     bcd_q;
    logic                   neg_q;
    logic                   ovf_q;
    logic [3:0]             count_q;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [BCD_TOT-1:0]     adj_d;        // scratch after add-3 correction
    logic [BCD_TOT-1:0]     scratch_d;    // scratch after shift
    logic                   carry_d;      // bit shifted out of the top digit
    logic [IN_WIDTH-1:0]    mag_d;
    logic [NUM_DIGITS-1:0]  digit_nz_d;
    logic                   ovf_d;
    logic [3:0]             count_d;
    logic                   load_sign_d;
    logic [IN_WIDTH-1:0]    load_mag_d;
    logic                   accept_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            result_bcd_converter_dabble_digit u_dabble (
                .digit_i (scratch_q[gi*BCD_W +: BCD_W]),
                .digit_o (adj_d[gi*BCD_W +: BCD_W])
            );
            assign digit_nz_d[gi] = |scratch_q[gi*BCD_W +: BCD_W];
        end
    endgenerate

    // Corrected digits and magnitude shift left together as one long register.
    assign {carry_d, scratch_d} = {adj_d, mag_q[IN_WIDTH-1]};
    assign mag_d                = {mag_q[IN_WIDTH-2:0], 1'b0};

    // Sign and magnitude of the captured operand. Negating the most negative
    // value wraps to itself, which read as unsigned is the correct magnitude.
    assign load_sign_d = smode_q & bin_q[IN_WIDTH-1];
    assign load_mag_d  = load_sign_d ? (~bin_q + IN_WIDTH'(1)) : bin_q;

    generate
        if (NUM_DIGITS > DISP_DIGITS) begin : g_ovf
            assign ovf_d = (|digit_nz_d[NUM_DIGITS-1:DISP_DIGITS]) | lost_q;
        end else begin : g_no_ovf
            assign ovf_d = lost_q;
        end
    endgenerate

    // Highest nonzero digit wins; all-zero still shows a single "0".
    always_comb begin
        count_d = 4'd1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_nz_d[i]) begin
                count_d = 4'(i + 1);
            end
        end
    end

    assign accept_d = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            smode_q   <= 1'b0;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            scratch_q <= '0;
            lost_q    <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            count_q   <= 4'd1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        bin_q   <= bin_in;
                        smode_q <= signed_mode;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    sign_q    <= load_sign_d;
                    mag_q     <= load_mag_d;
                    scratch_q <= '0;
                    lost_q    <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    scratch_q <= scratch_d;
                    mag_q     <= mag_d;
                    lost_q    <= lost_q | carry_d;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done_q  <= 1'b1;
                    bcd_q   <= scratch_q;
                    // A zero magnitude is never shown as negative.
                    neg_q   <= sign_q & (|digit_nz_d);
                    ovf_q   <= ovf_d;
                    count_q <= count_d;
                    if (accept_d) begin
                        bin_q   <= bin_in;
                        smode_q <= signed_mode;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign bcd_out     = bcd_q;
    assign negative    = neg_q;
    assign overflow    = ovf_q;
    assign digit_count = count_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
module tb_result_bcd_converter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic [31:0] bin_in;
    logic        busy;
    logic        done;
    logic [39:0] bcd_out;
    logic        negative;
    logic        overflow;
    logic [3:0]  digit_count;

    int errors = 0;
    int checks = 0;

    result_bcd_converter dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .bin_in      (bin_in),
        .busy        (busy),
        .done        (done),
        .bcd_out     (bcd_out),
        .negative    (negative),
        .overflow    (overflow),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          sm;
        logic [31:0] val;
        logic [39:0] bcd;
        bit          neg;
        bit          ovf;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the value's magnitude.
    function automatic void ref_model(input bit sm, input logic [31:0] v,
                                      output logic [39:0] bcd, output bit neg,
                                      output bit ovf, output logic [3:0] cnt);
        longint unsigned m;
        longint unsigned t;
        int nd;
        m   = 64'(v);
        neg = 1'b0;
        if (sm && v[31]) begin
            m   = 64'd4294967296 - 64'(v);
            neg = (m != 0);
        end
        ovf = (m > 64'd99999999);
        bcd = '0;
        t   = m;
        for (int i = 0; i < 10; i++) begin
            bcd[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        nd = 0;
        t  = m;
        while (t != 0) begin
            nd++;
            t = t / 10;
        end
        cnt = (nd == 0) ? 4'd1 : 4'(nd);
    endfunction

    task automatic check_result(input string tag, input logic [39:0] e_bcd, input bit e_neg,
                                input bit e_ovf, input logic [3:0] e_cnt);
        chk({tag, "_bcd"}, 64'(bcd_out), 64'(e_bcd));
        chk({tag, "_neg"}, 64'(negative), 64'(e_neg));
        chk({tag, "_ovf"}, 64'(overflow), 64'(e_ovf));
        chk({tag, "_cnt"}, 64'(digit_count), 64'(e_cnt));
    endtask

    // One isolated conversion: start for a single cycle, bin_in scrambled while busy.
    task automatic run_conv(input string tag, input bit sm, input logic [31:0] v,
                            input logic [39:0] e_bcd, input bit e_neg, input bit e_ovf,
                            input logic [3:0] e_cnt);
        int lat;
        @(negedge clk);
        signed_mode = sm;
        bin_in      = v;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            bin_in      = $urandom;
            signed_mode = 1'($urandom);
        end
        chk({tag, "_latency"}, 64'(lat), 64'(34));
        check_result(tag, e_bcd, e_neg, e_ovf, e_cnt);
        $display("%s: sm=%0d in=%h -> bcd=%h neg=%0d ovf=%0d cnt=%0d lat=%0d",
                 tag, sm, v, bcd_out, negative, overflow, digit_count, lat);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_held_bcd"}, 64'(bcd_out), 64'(e_bcd));
    endtask

    initial begin
        logic [39:0] e_bcd;
        bit          e_neg;
        bit          e_ovf;
        logic [3:0]  e_cnt;
        logic [31:0] va;
        logic [31:0] vb;
        bit          sm;
        int          pulses;

        tbl[0]  = '{1'b0, 32'd0,         40'h0000000000, 1'b0, 1'b0, 4'd1};
        tbl[1]  = '{1'b0, 32'd12345678,  40'h0012345678, 1'b0, 1'b0, 4'd8};
        tbl[2]  = '{1'b0, 32'd100000000, 40'h0100000000, 1'b0, 1'b1, 4'd9};
        tbl[3]  = '{1'b1, 32'hFFFFFFFF,  40'h0000000001, 1'b1, 1'b0, 4'd1};
        tbl[4]  = '{1'b1, 32'h80000000,  40'h2147483648, 1'b1, 1'b1, 4'd10};
        tbl[5]  = '{1'b0, 32'hFFFFFFFF,  40'h4294967295, 1'b0, 1'b1, 4'd10};
        tbl[6]  = '{1'b1, 32'd0,         40'h0000000000, 1'b0, 1'b0, 4'd1};
        tbl[7]  = '{1'b1, 32'd99999999,  40'h0099999999, 1'b0, 1'b0, 4'd8};
        tbl[8]  = '{1'b1, 32'hFA0A1F01,  40'h0099999999, 1'b1, 1'b0, 4'd8};
        tbl[9]  = '{1'b0, 32'd9,         40'h0000000009, 1'b0, 1'b0, 4'd1};
        tbl[10] = '{1'b0, 32'd10,        40'h0000000010, 1'b0, 1'b0, 4'd2};

        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        bin_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        check_result("reset", 40'h0, 1'b0, 1'b0, 4'd1);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run_conv($sformatf("vec%0d", i), tbl[i].sm, tbl[i].val,
                     tbl[i].bcd, tbl[i].neg, tbl[i].ovf, tbl[i].cnt);
        end

        // start held high with bin_in toggling; back-to-back accept in DONE
        va = 32'd87654321;
        vb = $urandom;
        pulses = 0;
        @(negedge clk);
        signed_mode = 1'b0;
        bin_in      = va;
        start       = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (n == 34) begin
                    ref_model(1'b0, va, e_bcd, e_neg, e_ovf, e_cnt);
                    check_result("b2b_first", e_bcd, e_neg, e_ovf, e_cnt);
                    $display("b2b_first: in=%h -> bcd=%h at cycle %0d", va, bcd_out, n);
                end else if (n == 68) begin
                    ref_model(1'b0, vb, e_bcd, e_neg, e_ovf, e_cnt);
                    check_result("b2b_second", e_bcd, e_neg, e_ovf, e_cnt);
                    $display("b2b_second: in=%h -> bcd=%h at cycle %0d", vb, bcd_out, n);
                end else begin
                    chk("b2b_unexpected_done_cycle", 64'(n), 64'(0));
                end
            end
            if (n == 34) chk("b2b_no_gap_busy", 64'(busy), 64'd1);
            if (n == 33) bin_in = vb;
            else         bin_in = $urandom;
            if (n == 67) start = 1'b0;
        end
        chk("b2b_pulse_count", 64'(pulses), 64'd2);

        // Reset in the middle of SHIFT
        run_conv("pre_reset", 1'b0, 32'd4242, 40'h0000004242, 1'b0, 1'b0, 4'd4);
        @(negedge clk);
        signed_mode = 1'b1;
        bin_in      = 32'hFFFFFF00;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        check_result("midreset", 40'h0, 1'b0, 1'b0, 4'd1);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("midreset_no_done", 64'(pulses), 64'd0);
        $display("midreset: outputs cleared, done pulses after abort=%0d", pulses);
        run_conv("post_reset", 1'b1, 32'hFFFFFF00, 40'h0000000256, 1'b1, 1'b0, 4'd3);

        // Randomized against the reference model
        for (int i = 0; i < 30; i++) begin
            sm = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       va = $urandom_range(0, 1000);
                1:       va = 32'd0 - $urandom_range(0, 1000);
                2:       va = $urandom_range(99999000, 100001000);
                default: va = $urandom;
            endcase
            ref_model(sm, va, e_bcd, e_neg, e_ovf, e_cnt);
            run_conv($sformatf("rand%0d", i), sm, va, e_bcd, e_neg, e_ovf, e_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
